cumulative_shift_gen_mc: RTL

Multi-channel, runtime-configurable successor to the single-channel cumulative shift-offset generator. For every channel it accumulates a stream of per-round shift increments modulo a shared-bank count selected at frame start, and emits the cumulative offsets that drive the QSN barrel shifters and micro bit-shift generators. It sits between the layer scheduler (increment source) and the shifter bank, with valid/ready handshakes on both sides.

---
 rtl/cumulative_shift_gen_mc.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cumulative_shift_gen_mc.sv
// Multi-channel cumulative shift-offset generator.
// Each channel accumulates per-round shift increments modulo the active
// shared-bank count and emits cumulative offsets for the QSN shifters.
// Two-stage pipeline: stage 1 holds the accumulators, stage 2 the outputs.
module cumulative_shift_gen_mc #(
  parameter int CH_NUM       = 4,
  parameter int MAX_BANK_NUM = 255,
  parameter int SHIFT_WIDTH  = $clog2(MAX_BANK_NUM),
  parameter int BANK_WIDTH   = $clog2(MAX_BANK_NUM + 1),
  parameter int FRAME_LEN    = 16,
  parameter int ROUND_WIDTH  = $clog2(FRAME_LEN)
) (
  input  logic                          sys_clk,
  input  logic                          rstn,
  input  logic [BANK_WIDTH-1:0]         cfg_bank_num,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_frame_start,
  input  logic [CH_NUM*SHIFT_WIDTH-1:0] in_shift,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_NUM*SHIFT_WIDTH-1:0] out_offset,
  output logic [CH_NUM-1:0]             out_wrap,
  output logic [ROUND_WIDTH-1:0]        out_round,
  output logic                          out_frame_last,
  output logic                          err_sticky
);

  // One extra bit so acc + inc never overflows before the modulo step.
  localparam int SUM_WIDTH = SHIFT_WIDTH + 1;
  localparam logic [BANK_WIDTH:0]      MAX_M_WIDE = (BANK_WIDTH + 1)'(MAX_BANK_NUM);
  localparam logic [BANK_WIDTH-1:0]    MAX_M      = BANK_WIDTH'(MAX_BANK_NUM);
  localparam logic [BANK_WIDTH-1:0]    MIN_M      = BANK_WIDTH'(2);
  localparam logic [ROUND_WIDTH-1:0]   LAST_ROUND = ROUND_WIDTH'(FRAME_LEN - 1);

  logic                          en;
  logic                          accept;

  // Stage 1 state: accumulators double as the offsets of the last accepted beat.
  logic                          s1_valid;
  logic [BANK_WIDTH-1:0]         m_act;
  logic [CH_NUM*SHIFT_WIDTH-1:0] acc;
  logic [CH_NUM-1:0]             s1_wrap;
  logic [ROUND_WIDTH-1:0]        s1_round;
  logic                          started;

  logic                          cfg_bad;
  logic [BANK_WIDTH-1:0]         m_sel;
  logic [SUM_WIDTH-1:0]          m_ext;
  logic [ROUND_WIDTH-1:0]        round_nxt;
  logic                          overrun;
  logic [CH_NUM*SHIFT_WIDTH-1:0] acc_nxt;
  logic [CH_NUM-1:0]             wrap_nxt;
  logic [CH_NUM-1:0]             inc_bad;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = en && in_valid;

  // Pick the modulus that applies to the current beat (new one on frame start).
  always_comb begin
    cfg_bad = (cfg_bank_num < MIN_M) || ({1'b0, cfg_bank_num} > MAX_M_WIDE);
    m_sel   = m_act;
    if (in_frame_start) begin
      m_sel = cfg_bad ? MAX_M : cfg_bank_num;
    end
    m_ext = SUM_WIDTH'(m_sel);
  end

  // Round index of the current beat; the very first beat after reset is round 0.
  always_comb begin
    overrun   = 1'b0;
    round_nxt = s1_round + ROUND_WIDTH'(1);
    if (in_frame_start || !started) begin
      round_nxt = '0;
    end else if (s1_round == LAST_ROUND) begin
      round_nxt = '0;
      overrun   = 1'b1;
    end
  end

  // Per-channel modular accumulation; out-of-range increments count as zero.
  always_comb begin
    logic [SUM_WIDTH-1:0] inc_ext;
    logic [SUM_WIDTH-1:0] acc_ext;
    logic [SUM_WIDTH-1:0] sum;
    acc_nxt  = acc;
    wrap_nxt = '0;
    inc_bad  = '0;
    inc_ext  = '0;
    acc_ext  = '0;
    sum      = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      inc_ext = SUM_WIDTH'(in_shift[c*SHIFT_WIDTH +: SHIFT_WIDTH]);
      acc_ext = SUM_WIDTH'(acc[c*SHIFT_WIDTH +: SHIFT_WIDTH]);
      if (inc_ext >= m_ext) begin
        inc_ext    = '0;
        inc_bad[c] = 1'b1;
      end
      sum = in_frame_start ? inc_ext : (acc_ext + inc_ext);
      if (!in_frame_start && (sum >= m_ext)) begin
        sum         = sum - m_ext;
        wrap_nxt[c] = 1'b1;
      end
      acc_nxt[c*SHIFT_WIDTH +: SHIFT_WIDTH] = sum[SHIFT_WIDTH-1:0];
    end
  end

  // Stage 1: capture the accepted beat's accumulation results.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      m_act    <= MAX_M;
      acc      <= '0;
      s1_wrap  <= '0;
      s1_round <= '0;
      started  <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        m_act    <= m_sel;
        acc      <= acc_nxt;
        s1_wrap  <= wrap_nxt;
        s1_round <= round_nxt;
        started  <= 1'b1;
      end
    end
  end

  // Sticky error: bad modulus, out-of-range increment or frame overrun.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      err_sticky <= 1'b0;
    end else if (accept && ((in_frame_start && cfg_bad) || (|inc_bad) || overrun)) begin
      err_sticky <= 1'b1;
    end
  end

  // Stage 2: registered outputs, frozen while the downstream stalls.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      out_valid      <= 1'b0;
      out_offset     <= '0;
      out_wrap       <= '0;
      out_round      <= '0;
      out_frame_last <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_offset     <= acc;
        out_wrap       <= s1_wrap;
        out_round      <= s1_round;
        out_frame_last <= (s1_round == LAST_ROUND);
      end
    end
  end

endmodule
